alarm_bank: RTL and testbench

- Parametrised alarm unit for the digital-clock datapath, sitting between the timekeeping counter and the 7-segment display driver.
- Selects which time (clock or any of N alarms) goes to the display.
- Detects clock/alarm matches and holds a per-alarm ringing state with pause dismissal, auto-timeout and optional snooze.
- Generalises the fixed three-alarm mux/comparator to N alarms, latched edge-triggered ringing and a buzzer output.

---
 rtl/alarm_bank_if.sv | 34 +++
 rtl/alarm_bank.sv | 190 +++++++++++++++++++
 tb/tb_alarm_bank.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alarm_bank_if.sv
// Signal bundle between the timekeeping/control side and the alarm bank.
// The bank sits on the slave modport; its driver sits on the master modport.
interface alarm_bank_if #(
    parameter int N_ALARMS = 3,
    parameter int TIME_W   = 24
);
    localparam int AA_W = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1;

    logic                         tick_1hz;
    logic [TIME_W-1:0]            horario_relogio;
    logic [N_ALARMS*TIME_W-1:0]   horario_alarmes;
    logic [N_ALARMS-1:0]          alarme_en;
    logic                         sel_relogio;
    logic [N_ALARMS-1:0]          sel_alarme;
    logic                         botao_pause;
    logic                         botao_snooze;
    logic [TIME_W-1:0]            horario_saida;
    logic [N_ALARMS-1:0]          comparador;
    logic                         buzzer;
    logic [AA_W-1:0]              alarme_ativo;
    logic                         snooze_ativo;

    modport master (
        output tick_1hz, horario_relogio, horario_alarmes, alarme_en,
               sel_relogio, sel_alarme, botao_pause, botao_snooze,
        input  horario_saida, comparador, buzzer, alarme_ativo, snooze_ativo
    );

    modport slave (
        input  tick_1hz, horario_relogio, horario_alarmes, alarme_en,
               sel_relogio, sel_alarme, botao_pause, botao_snooze,
        output horario_saida, comparador, buzzer, alarme_ativo, snooze_ativo
    );
endinterface

// File: rtl/alarm_bank.sv
// N-channel alarm unit: registered display mux, edge-triggered match detection,
// per-channel ringing FSM with timeout. Snooze support under `define ALARM_SNOOZE_EN.
module alarm_bank_chan #(
    parameter int RING_TIMEOUT = 60,
    parameter int SNOOZE_SECS  = 300,
    parameter int CNT_W        = 9
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic en,
    input  logic fire,
    input  logic pause_rise,
    input  logic snooze_rise,
    output logic ringing,
    output logic snoozing
);
`ifdef ALARM_SNOOZE_EN
    typedef enum logic [1:0] {IDLE, RINGING, SNOOZE} state_t;
`else
    typedef enum logic {IDLE, RINGING} state_t;
`endif

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               cnt_one;

    assign cnt_one = (cnt_q == CNT_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Same-edge priority: disable > pause > snooze > expiry > fire > plain tick.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fire) begin
                        state_d = RINGING;
                        cnt_d   = CNT_W'(RING_TIMEOUT);
                    end
                end
                RINGING: begin
                    if (pause_rise) begin
                        state_d = IDLE;
`ifdef ALARM_SNOOZE_EN
                    end else if (snooze_rise) begin
                        state_d = SNOOZE;
                        cnt_d   = CNT_W'(SNOOZE_SECS);
`endif
                    end else if (tick && cnt_one && RING_TIMEOUT != 0) begin
                        state_d = IDLE;
                    end else if (fire) begin
                        cnt_d = CNT_W'(RING_TIMEOUT);
                    end else if (tick && cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
`ifdef ALARM_SNOOZE_EN
                SNOOZE: begin
                    if (pause_rise) begin
                        state_d = IDLE;
                    end else if (tick && cnt_one) begin
                        state_d = RINGING;
                        cnt_d   = CNT_W'(RING_TIMEOUT);
                    end else if (tick && cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    assign ringing = (state_q == RINGING);
`ifdef ALARM_SNOOZE_EN
    assign snoozing = (state_q == SNOOZE);
`else
    logic unused_snooze_rise;
    assign unused_snooze_rise = snooze_rise;
    assign snoozing = 1'b0;
`endif
endmodule

module alarm_bank #(
    parameter int N_ALARMS     = 3,
    parameter int TIME_W       = 24,
    parameter int RING_TIMEOUT = 60,
    parameter int SNOOZE_SECS  = 300
) (
    input  logic       clk,
    input  logic       reset,
    alarm_bank_if.slave bus
);
    localparam int AA_W    = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1;
    localparam int MAX_CNT = (RING_TIMEOUT > SNOOZE_SECS) ? RING_TIMEOUT : SNOOZE_SECS;
    localparam int CNT_W   = (MAX_CNT > 0) ? $clog2(MAX_CNT + 1) : 1;

    logic [N_ALARMS-1:0][TIME_W-1:0] alarm_t;
    logic [N_ALARMS-1:0]             match, match_q, fire;
    logic [N_ALARMS-1:0]             ringing, snoozing;
    logic                            pause_q, pause_rise, snooze_rise;
    logic [TIME_W-1:0]               disp_d;
    logic [AA_W-1:0]                 aa;

    assign alarm_t = bus.horario_alarmes;

    always_comb begin
        match = '0;
        for (int i = 0; i < N_ALARMS; i++)
            match[i] = bus.alarme_en[i] && (bus.horario_relogio == alarm_t[i]);
    end

    // Rising edge only, so an equality held for a whole second rings once.
    assign fire       = match & ~match_q & {N_ALARMS{~bus.botao_pause}};
    assign pause_rise = bus.botao_pause & ~pause_q;

`ifdef ALARM_SNOOZE_EN
    logic snooze_q;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) snooze_q <= 1'b0;
        else       snooze_q <= bus.botao_snooze;
    end
    assign snooze_rise = bus.botao_snooze & ~snooze_q;
`else
    logic unused_botao_snooze;
    assign unused_botao_snooze = bus.botao_snooze;
    assign snooze_rise = 1'b0;
`endif

    always_comb begin
        disp_d = bus.horario_saida;
        for (int i = N_ALARMS - 1; i >= 0; i--)
            if (bus.sel_alarme[i]) disp_d = alarm_t[i];
        if (bus.sel_relogio) disp_d = bus.horario_relogio;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.horario_saida <= '0;
            match_q           <= '0;
            pause_q           <= 1'b0;
        end else begin
            bus.horario_saida <= disp_d;
            match_q           <= match;
            pause_q           <= bus.botao_pause;
        end
    end

    for (genvar g = 0; g < N_ALARMS; g++) begin : g_chan
        alarm_bank_chan #(
            .RING_TIMEOUT (RING_TIMEOUT),
            .SNOOZE_SECS  (SNOOZE_SECS),
            .CNT_W        (CNT_W)
        ) u_chan (
            .clk         (clk),
            .reset       (reset),
            .tick        (bus.tick_1hz),
            .en          (bus.alarme_en[g]),
            .fire        (fire[g]),
            .pause_rise  (pause_rise),
            .snooze_rise (snooze_rise),
            .ringing     (ringing[g]),
            .snoozing    (snoozing[g])
        );
    end

    always_comb begin
        aa = '0;
        for (int i = N_ALARMS - 1; i >= 0; i--)
            if (ringing[i]) aa = AA_W'(i);
    end

    assign bus.comparador   = ringing;
    assign bus.buzzer       = |ringing;
    assign bus.alarme_ativo = aa;
    assign bus.snooze_ativo = |snoozing;
endmodule

// File: tb/tb_alarm_bank.sv
// Randomized + directed bench for alarm_bank with a per-second alarm model and
// an expected-output queue drained by an independent monitor.
module tb_alarm_bank;
    localparam int N  = 3;
    localparam int TW = 24;
    localparam int RT = 3;
    localparam int SS = 2;

    logic clk, reset;
    alarm_bank_if #(.N_ALARMS(N), .TIME_W(TW)) bus ();

    alarm_bank #(.N_ALARMS(N), .TIME_W(TW), .RING_TIMEOUT(RT), .SNOOZE_SECS(SS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [TW-1:0] disp;
        logic [N-1:0]  cmp;
        logic          buz;
        logic [1:0]    aa;
        logic          snz;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Model state: 0 idle, 1 ringing, 2 snoozing; seconds left in that phase.
    int            mode[N];
    int            left[N];
    bit            m_prev[N];
    bit            p_prev, s_prev;
    logic [TW-1:0] m_disp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [TW-1:0] alarm_of(input int i);
        logic [N*TW-1:0] v;
        v = bus.horario_alarmes;
        return v[i*TW +: TW];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mode[i] = 0; left[i] = 0; m_prev[i] = 0;
        end
        p_prev = 0; s_prev = 0; m_disp = '0;
    endtask

    // Advance the model by one clock using the inputs that were present at the edge.
    task automatic model_step();
        exp_t e;
        bit   snz_en, prise, srise, m, f;
`ifdef ALARM_SNOOZE_EN
        snz_en = 1;
`else
        snz_en = 0;
`endif
        if (reset) begin
            model_reset();
        end else begin
            if (bus.sel_relogio) m_disp = bus.horario_relogio;
            else begin
                for (int i = N - 1; i >= 0; i--)
                    if (bus.sel_alarme[i]) m_disp = alarm_of(i);
            end
            prise = bus.botao_pause && !p_prev;
            srise = snz_en && bus.botao_snooze && !s_prev;
            for (int i = 0; i < N; i++) begin
                m = bus.alarme_en[i] && (bus.horario_relogio == alarm_of(i));
                f = m && !m_prev[i] && !bus.botao_pause;
                m_prev[i] = m;
                if (!bus.alarme_en[i] || prise) mode[i] = 0;
                else if (srise && mode[i] == 1) begin mode[i] = 2; left[i] = SS; end
                else if (mode[i] == 1 && bus.tick_1hz && RT != 0 && left[i] == 1) mode[i] = 0;
                else if (mode[i] == 2 && bus.tick_1hz && left[i] == 1) begin mode[i] = 1; left[i] = RT; end
                else if (f && mode[i] != 2) begin mode[i] = 1; left[i] = RT; end
                else if (bus.tick_1hz && mode[i] != 0 && left[i] > 0) left[i]--;
            end
            p_prev = bus.botao_pause;
            s_prev = bus.botao_snooze;
        end
        e.disp = m_disp; e.cmp = '0; e.aa = '0; e.snz = 0;
        for (int i = 0; i < N; i++) begin
            e.cmp[i] = (mode[i] == 1);
            if (mode[i] == 2) e.snz = 1;
        end
        for (int i = N - 1; i >= 0; i--) if (mode[i] == 1) e.aa = 2'(i);
        e.buz = |e.cmp;
        q.push_back(e);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        model_step();
    endtask

    task automatic tick_pulse();
        bus.tick_1hz = 1'b1;
        cycle();
        bus.tick_1hz = 1'b0;
    endtask

    task automatic set_alarm(input int i, input logic [TW-1:0] v);
        logic [N*TW-1:0] a;
        a = bus.horario_alarmes;
        a[i*TW +: TW] = v;
        bus.horario_alarmes = a;
    endtask

    // Monitor: every clock the DUT presents a new output word.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("disp",         32'(bus.horario_saida), 32'(e.disp));
                chk("comparador",   32'(bus.comparador),    32'(e.cmp));
                chk("buzzer",       32'(bus.buzzer),        32'(e.buz));
                chk("alarme_ativo", 32'(bus.alarme_ativo),  32'(e.aa));
                chk("snooze_ativo", 32'(bus.snooze_ativo),  32'(e.snz));
            end
        end
    end

    logic [TW-1:0] pool[4] = '{24'h073000, 24'h120000, 24'h063000, 24'h000001};

    initial begin
        reset = 1'b1;
        bus.tick_1hz = 0; bus.horario_relogio = '0; bus.horario_alarmes = '0;
        bus.alarme_en = '0; bus.sel_relogio = 0; bus.sel_alarme = '0;
        bus.botao_pause = 0; bus.botao_snooze = 0;
        model_reset();
        #1;
        chk("reset_cmp",  32'(bus.comparador),    32'h0);
        chk("reset_disp", 32'(bus.horario_saida), 32'h0);
        cycle(); cycle();
        reset = 1'b0;

        // Display mux
        bus.horario_relogio = 24'h000100;
        set_alarm(1, 24'h063000);
        bus.sel_alarme = 3'b110;
        cycle();
        chk("mux_alarm1", 32'(bus.horario_saida), 32'h063000);
        bus.sel_relogio = 1;
        cycle();
        chk("mux_clock", 32'(bus.horario_saida), 32'h000100);
        bus.sel_relogio = 0; bus.sel_alarme = '0; bus.horario_relogio = 24'h000200;
        cycle();
        chk("mux_hold", 32'(bus.horario_saida), 32'h000100);

        // Single fire, held equality rings once
        set_alarm(0, 24'h073000); bus.alarme_en = 3'b001;
        bus.horario_relogio = 24'h072959;
        cycle(); cycle();
        bus.horario_relogio = 24'h073000;
        cycle();
        chk("fire_cmp", 32'(bus.comparador),   32'h1);
        chk("fire_aa",  32'(bus.alarme_ativo), 32'h0);
        chk("fire_buz", 32'(bus.buzzer),       32'h1);
        repeat (50) cycle();
        chk("hold_cmp", 32'(bus.comparador), 32'h1);

        // Timeout after RT ticks, then re-match rings again
        tick_pulse(); tick_pulse();
        chk("pre_timeout", 32'(bus.comparador), 32'h1);
        tick_pulse();
        chk("timeout", 32'(bus.comparador), 32'h0);
        bus.horario_relogio = 24'h073001; cycle();
        bus.horario_relogio = 24'h073000; cycle();
        chk("refire", 32'(bus.comparador), 32'h1);
        bus.botao_pause = 1; cycle();
        bus.botao_pause = 0; cycle();

        // Simultaneous + pause, match lost while pause held
        set_alarm(1, 24'h120000); set_alarm(2, 24'h120000); bus.alarme_en = 3'b111;
        bus.horario_relogio = 24'h115959; cycle();
        bus.horario_relogio = 24'h120000; cycle();
        chk("simul_cmp", 32'(bus.comparador),   32'h6);
        chk("simul_aa",  32'(bus.alarme_ativo), 32'h1);
        bus.botao_pause = 1; cycle();
        chk("pause_dismiss", 32'(bus.comparador), 32'h0);
        bus.horario_relogio = 24'h115959; cycle();
        bus.horario_relogio = 24'h120000; cycle();
        bus.botao_pause = 0; cycle();
        chk("paused_match_lost", 32'(bus.comparador), 32'h0);

        // Snooze
        bus.horario_relogio = 24'h073001; cycle();
        bus.horario_relogio = 24'h073000; cycle();
        chk("snz_pre", 32'(bus.comparador), 32'h1);
        bus.botao_snooze = 1; cycle();
        bus.botao_snooze = 0;
`ifdef ALARM_SNOOZE_EN
        chk("snz_cmp",  32'(bus.comparador),   32'h0);
        chk("snz_flag", 32'(bus.snooze_ativo), 32'h1);
`else
        chk("snz_cmp",  32'(bus.comparador),   32'h1);
        chk("snz_flag", 32'(bus.snooze_ativo), 32'h0);
`endif
        tick_pulse(); tick_pulse();
        chk("snz_back_cmp",  32'(bus.comparador),   32'h1);
        chk("snz_back_flag", 32'(bus.snooze_ativo), 32'h0);

        // Async reset mid-ring
        bus.botao_pause = 1; cycle(); bus.botao_pause = 0; cycle();
        bus.alarme_en = 3'b010; set_alarm(1, 24'h063000); bus.sel_relogio = 1;
        bus.horario_relogio = 24'h062959; cycle();
        bus.horario_relogio = 24'h063000; cycle();
        chk("pre_reset_cmp", 32'(bus.comparador), 32'h2);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("async_cmp",  32'(bus.comparador),    32'h0);
        chk("async_buz",  32'(bus.buzzer),        32'h0);
        chk("async_disp", 32'(bus.horario_saida), 32'h0);
        cycle();
        reset = 1'b0;

        // Random phase
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(2) == 0) bus.horario_relogio = pool[$urandom_range(3)];
            if ($urandom_range(49) == 0) set_alarm($urandom_range(N - 1), pool[$urandom_range(3)]);
            if ($urandom_range(39) == 0) bus.alarme_en = 3'($urandom_range(7) | $urandom_range(7));
            if ($urandom_range(4) == 0) begin
                bus.sel_relogio = 1'($urandom_range(1));
                bus.sel_alarme  = 3'($urandom_range(7));
            end
            if ($urandom_range(19) == 0) bus.botao_pause  = ~bus.botao_pause;
            if ($urandom_range(14) == 0) bus.botao_snooze = ~bus.botao_snooze;
            bus.tick_1hz = ($urandom_range(3) == 0);
            cycle();
        end
        bus.tick_1hz = 0;

        @(negedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
